// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   state_e    : arbiter FSM encoding (IDLE -> BUSY -> DONE -> IDLE)
//   OWN_IF/DM  : owner id of the transaction holding the memory
//   MEM_LAT_MAX: largest supported access latency
//   LAT_CNT_W  : width of the latency down-counter
package mem_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OWN_IF      = 1'b0;
  localparam logic OWN_DM      = 1'b1;
  localparam int   MEM_LAT_MAX = 15;
  localparam int   LAT_CNT_W   = 4;
endpackage

// File: rtl/mem_arb_lat_counter.sv
// mem_lat_counter: loadable down-counter that times one memory access.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : load load_val_i (wins over en_i)
//   load_val_i   : value to load
//   en_i         : decrement by one (saturates at zero)
//   zero_o       : counter currently zero
module mem_lat_counter
  import mem_arb_pkg::*;
#(
  parameter int CNT_W = LAT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                    cnt_d = load_val_i;
    else if (en_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction
// fetch (IF) and load/store (DM). One transaction at a time; the memory is
// held for MEM_LAT cycles, then the owner gets a one-cycle ack with its
// read data registered.
//   IF side : if_req_i, if_addr_i -> if_rdata_o, if_ack_o, stall_if_o
//   DM side : dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i -> dm_rdata_o,
//             dm_ack_o, stall_mem_o
//   Memory  : mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o <- mem_rdata_i
// Build option ARB_FAIR_EN: when both sides wait, grant the one that was
// not granted last (last-grant resets to IF). Undefined: DM always wins.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_if_o,
  output logic              stall_mem_o
);
  // Out-of-range latencies are clamped into 1..MEM_LAT_MAX.
  localparam int LAT_EFF = (MEM_LAT < 1) ? 1 :
                           (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LAT_EFF - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q, owner_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              grant, win, last_beat, cnt_zero;

`ifdef ARB_FAIR_EN
  logic last_q;

  always_comb begin
    if (if_req_i && dm_req_i) win = (last_q == OWN_DM) ? OWN_IF : OWN_DM;
    else                      win = dm_req_i ? OWN_DM : OWN_IF;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      last_q <= OWN_IF;
    else if (grant) last_q <= win;
  end
`else
  assign win = dm_req_i ? OWN_DM : OWN_IF;
`endif

  mem_lat_counter #(.CNT_W(LAT_CNT_W)) u_lat_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (grant),
    .load_val_i (LAT_LOAD),
    .en_i       (mem_en_o),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    last_beat = 1'b0;
    mem_en_o  = 1'b0;
    mem_we_o  = 1'b0;
    if_ack_o  = 1'b0;
    dm_ack_o  = 1'b0;
    case (state_q)
      ST_IDLE: if (if_req_i || dm_req_i) begin
        grant   = 1'b1;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        mem_en_o = 1'b1;
        // Write strobe only on the final beat: exactly one write per store.
        if (cnt_zero) begin
          last_beat = 1'b1;
          mem_we_o  = we_q;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if_ack_o = (owner_q == OWN_IF);
        dm_ack_o = (owner_q == OWN_DM);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      owner_q    <= OWN_IF;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      // Requester inputs are only looked at here; BUSY runs off the copies.
      if (grant) begin
        owner_q <= win;
        addr_q  <= (win == OWN_DM) ? dm_addr_i : if_addr_i;
        wdata_q <= (win == OWN_DM) ? dm_wdata_i : '0;
        we_q    <= (win == OWN_DM) && dm_we_i;
      end
      if (last_beat && !we_q) begin
        if (owner_q == OWN_DM) dm_rdata_q <= mem_rdata_i;
        else                   if_rdata_q <= mem_rdata_i;
      end
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign stall_if_o  = if_req_i & ~if_ack_o;
  assign stall_mem_o = dm_req_i & ~dm_ack_o;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed requests against a 256-word memory,
// a transaction-timeline reference model checked every cycle, and literal
// expectations for the latency/priority/reset scenarios.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;
  localparam int AW = 32, DW = 32, LAT = 2;

  logic clk = 1'b0, rst = 1'b0;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic if_ack, dm_ack, mem_en, mem_we, stall_if, stall_mem;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata), .dm_ack_o(dm_ack),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .stall_if_o(stall_if), .stall_mem_o(stall_mem)
  );

  always #5 clk = ~clk;

  // Environment memory (what the DUT really talks to) and the model's view.
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  int checks = 0, errors = 0, cyc = 0, we_cnt = 0;
  bit run_chk = 1'b0;
  bit aq_own[$];
  int aq_cyc[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Reference model: a transaction is granted at an edge, occupies the
  // memory for LAT cycles, acks in the next, then one idle cycle follows.
  bit m_act, m_own, m_we, m_last, pick_dm;
  int m_ph;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_dm_rd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_ph = 0; m_own = OWN_IF; m_we = 0; m_last = OWN_IF;
      m_addr = '0; m_wdata = '0; m_if_rd = '0; m_dm_rd = '0;
    end else if (m_act) begin
      m_ph++;
      if (m_ph == LAT) begin
        if (m_we)                 ref_mem[m_addr[9:2]] = m_wdata;
        else if (m_own == OWN_DM) m_dm_rd = ref_mem[m_addr[9:2]];
        else                      m_if_rd = ref_mem[m_addr[9:2]];
      end else if (m_ph > LAT) m_act = 0;
    end else if (if_req || dm_req) begin
`ifdef ARB_FAIR_EN
      pick_dm = dm_req && !(if_req && m_last == OWN_DM);
`else
      pick_dm = dm_req;
`endif
      m_last  = pick_dm;
      m_own   = pick_dm;
      m_act   = 1;
      m_ph    = 0;
      m_addr  = pick_dm ? dm_addr : if_addr;
      m_wdata = pick_dm ? dm_wdata : '0;
      m_we    = pick_dm && dm_we;
    end
  end

  bit en_e, we_e, ia_e, da_e;
  always @(negedge clk) begin
    if (if_ack) begin aq_own.push_back(OWN_IF); aq_cyc.push_back(cyc); end
    if (dm_ack) begin aq_own.push_back(OWN_DM); aq_cyc.push_back(cyc); end
    if (mem_we) we_cnt++;
    if (run_chk) begin
      en_e = m_act && m_ph < LAT;
      we_e = en_e && m_ph == LAT - 1 && m_we;
      ia_e = m_act && m_ph == LAT && m_own == OWN_IF;
      da_e = m_act && m_ph == LAT && m_own == OWN_DM;
      chk("m_en", {31'd0, mem_en}, {31'd0, en_e});
      chk("m_we", {31'd0, mem_we}, {31'd0, we_e});
      if (en_e) chk("m_addr", mem_addr, m_addr);
      if (we_e) chk("m_wdata", mem_wdata, m_wdata);
      chk("m_if_ack", {31'd0, if_ack}, {31'd0, ia_e});
      chk("m_dm_ack", {31'd0, dm_ack}, {31'd0, da_e});
      chk("m_if_rdata", if_rdata, m_if_rd);
      chk("m_dm_rdata", dm_rdata, m_dm_rd);
      chk("m_stall_if", {31'd0, stall_if}, {31'd0, if_req & ~ia_e});
      chk("m_stall_mem", {31'd0, stall_mem}, {31'd0, dm_req & ~da_e});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Waits for the ack, then returns one ns into the following cycle.
  task automatic wait_ack(input bit own, input int maxc, output int acyc);
    acyc = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if ((own == OWN_DM) ? dm_ack : if_ack) begin acyc = cyc; break; end
    end
    if (acyc < 0) chk("ack_timeout", 32'd0, 32'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  int c, a, ad, ai;
  bit exp_own [5];
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    mem[4] = 32'h2002_0005;
    ref_mem[4] = 32'h2002_0005;

    // Reset state
    #2 rst = 1'b1;
    run_chk = 1'b1;
    @(negedge clk);
    chk("rst_en", {31'd0, mem_en}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    step();

    // 1: IF fetch only
    we_cnt = 0;
    if_addr = 32'h10; if_req = 1'b1; c = cyc;
    wait_ack(OWN_IF, 10, a);
    if_req = 1'b0;
    chk("t1_latency", a - c, 32'd3);
    chk("t1_rdata", if_rdata, 32'h2002_0005);
    chk("t1_we_cycles", we_cnt, 32'd0);

    // 2: store then load the same word
    we_cnt = 0;
    dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF; dm_we = 1'b1; dm_req = 1'b1; c = cyc;
    wait_ack(OWN_DM, 10, a);
    dm_we = 1'b0;
    chk("t2_store_lat", a - c, 32'd3);
    chk("t2_we_cycles", we_cnt, 32'd1);
    chk("t2_rdata_kept", dm_rdata, 32'd0);
    c = cyc;
    wait_ack(OWN_DM, 10, a);
    dm_req = 1'b0;
    chk("t2_load_lat", a - c, 32'd3);
    chk("t2_load_data", dm_rdata, 32'hDEAD_BEEF);
    chk("t2_mem_word", mem[16], 32'hDEAD_BEEF);
    step();

    // 3: simultaneous requests, DM first
    if_addr = 32'h10; dm_addr = 32'h40;
    if_req = 1'b1; dm_req = 1'b1; c = cyc;
    @(negedge clk);
    chk("t3_both_stall", {30'd0, stall_if, stall_mem}, 32'd3);
    wait_ack(OWN_DM, 10, ad);
    dm_req = 1'b0;
    wait_ack(OWN_IF, 10, ai);
    if_req = 1'b0;
    chk("t3_dm_ack_cyc", ad - c, 32'd3);
    chk("t3_if_ack_cyc", ai - c, 32'd7);
    step();

    // 4: DM held high with IF pending
    aq_own.delete(); aq_cyc.delete();
    dm_addr = 32'h40; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1; c = cyc;
    repeat (16) step();
    dm_req = 1'b0;
    wait_ack(OWN_IF, 10, a);
    if_req = 1'b0;
`ifdef ARB_FAIR_EN
    exp_own = '{OWN_DM, OWN_IF, OWN_DM, OWN_IF, OWN_IF};
`else
    exp_own = '{OWN_DM, OWN_DM, OWN_DM, OWN_DM, OWN_IF};
`endif
    chk("t4_n_acks", aq_own.size(), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < aq_own.size()) begin
        chk("t4_owner", {31'd0, aq_own[k]}, {31'd0, exp_own[k]});
        chk("t4_ack_cyc", aq_cyc[k] - c, 4 * k + 3);
      end
    end
    step();

    // 6: address change during BUSY is ignored
    dm_addr = 32'h40; dm_req = 1'b1; c = cyc;
    step();
    dm_addr = 32'h44;
    repeat (3) begin
      @(negedge clk);
      chk("t6_addr_held", mem_addr, 32'h40);
    end
    chk("t6_ack", {31'd0, dm_ack}, 32'd1);
    chk("t6_data", dm_rdata, 32'hDEAD_BEEF);
    step();
    dm_req = 1'b0;
    step();

    // 5: reset during the second BUSY cycle of a store
    aq_own.delete(); aq_cyc.delete();
    dm_addr = 32'h80; dm_wdata = 32'h5555_AAAA; dm_we = 1'b1; dm_req = 1'b1;
    step();
    step();
    #1 chk("t5_we_before", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1 chk("t5_we_at_rst", {31'd0, mem_we}, 32'd0);
    chk("t5_en_at_rst", {31'd0, mem_en}, 32'd0);
    dm_req = 1'b0; dm_we = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("t5_idle_en", {31'd0, mem_en}, 32'd0);
    chk("t5_no_ack", aq_own.size(), 32'd0);
    chk("t5_mem_kept", mem[32], 32'h1000_0020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
